// File: rtl/agenda_asteroide.sv
// agenda_asteroide: spawn scheduler feeding uc_gera_asteroide.
// Counts a per-level spawn interval, latches a pseudo-random position and heading
// from a free-running 16-bit Galois LFSR, pulses gera_asteroide, then waits
// (bounded) for the fim_gera_asteroide done pulse.
//
// Handshake: gera_asteroide is a single-cycle request issued from SOLICITA;
// the consumer answers with a single-cycle fim_gera_asteroide, which is only
// honoured while in AGUARDA. pos_x/pos_y/direcao are valid from the request
// cycle until the next SORTEIA. A missing answer is abandoned after TIMEOUT
// AGUARDA cycles and recorded in the sticky timeout flag.
module agenda_asteroide #(
    parameter int          PERIODO_INICIAL  = 1000,
    parameter int          PERIODO_MINIMO   = 200,
    parameter int          DECREMENTO       = 50,
    parameter int          SPAWNS_POR_NIVEL = 8,
    parameter int          TIMEOUT          = 64,
    parameter int          LARGURA_POS      = 4,
    parameter logic [15:0] SEMENTE          = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   habilita,
    input  logic                   pausa,
    input  logic                   fim_gera_asteroide,
    output logic                   gera_asteroide,
    output logic [LARGURA_POS-1:0] pos_x,
    output logic [LARGURA_POS-1:0] pos_y,
    output logic [2:0]             direcao,
    output logic [3:0]             nivel,
    output logic                   timeout,
    output logic [3:0]             db_estado
);

    localparam int SW = (SPAWNS_POR_NIVEL > 1) ? $clog2(SPAWNS_POR_NIVEL) : 1;

    // Period only drops while the result stays at or above the floor; the
    // 17-bit threshold keeps the comparison free of wrap-around.
    localparam logic [16:0] LIMIAR     = 17'(PERIODO_MINIMO + DECREMENTO);
    localparam logic [15:0] ULTIMO_TMO = 16'(TIMEOUT - 1);
    localparam logic [SW-1:0] ULTIMO_SP = SW'(SPAWNS_POR_NIVEL - 1);

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        CONTA    = 3'd1,
        SORTEIA  = 3'd2,
        SOLICITA = 3'd3,
        AGUARDA  = 3'd4,
        ATUALIZA = 3'd5
    } estado_t;

    estado_t         estado;
    logic [15:0]     lfsr;
    logic [15:0]     periodo;
    logic [15:0]     cnt;
    logic [SW-1:0]   spawns;

    // Free-running Galois LFSR (taps 16'hB400), advancing in every state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr <= SEMENTE;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Scheduler FSM with registered request, draw, level and timeout outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado         <= PARADO;
            gera_asteroide <= 1'b0;
            pos_x          <= '0;
            pos_y          <= '0;
            direcao        <= '0;
            nivel          <= '0;
            timeout        <= 1'b0;
            periodo        <= 16'(PERIODO_INICIAL);
            cnt            <= '0;
            spawns         <= '0;
        end else begin
            gera_asteroide <= 1'b0;
            case (estado)
                PARADO: begin
                    cnt <= '0;
                    if (habilita) begin
                        estado <= CONTA;
                    end
                end
                CONTA: begin
                    if (!habilita) begin
                        cnt    <= '0;
                        estado <= PARADO;
                    end else if (pausa) begin
                        cnt <= cnt;
                    end else if (cnt == periodo - 16'd1) begin
                        cnt    <= '0;
                        estado <= SORTEIA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SORTEIA: begin
                    pos_x          <= lfsr[LARGURA_POS+1:2];
                    pos_y          <= lfsr[2*LARGURA_POS+1:LARGURA_POS+2];
                    direcao        <= lfsr[15:13];
                    gera_asteroide <= 1'b1;
                    cnt            <= '0;
                    estado         <= SOLICITA;
                end
                SOLICITA: begin
                    cnt    <= '0;
                    estado <= AGUARDA;
                end
                AGUARDA: begin
                    // A done pulse wins over an expiry landing on the same cycle.
                    if (fim_gera_asteroide) begin
                        cnt    <= '0;
                        estado <= ATUALIZA;
                    end else if (cnt == ULTIMO_TMO) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                        estado  <= CONTA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ATUALIZA: begin
                    cnt    <= '0;
                    estado <= CONTA;
                    if (spawns == ULTIMO_SP) begin
                        spawns <= '0;
                        if (nivel != 4'hF) begin
                            nivel <= nivel + 4'd1;
                        end
                        if ({1'b0, periodo} >= LIMIAR) begin
                            periodo <= periodo - 16'(DECREMENTO);
                        end else begin
                            periodo <= 16'(PERIODO_MINIMO);
                        end
                    end else begin
                        spawns <= spawns + SW'(1);
                    end
                end
                default: begin
                    cnt    <= '0;
                    estado <= PARADO;
                end
            endcase
        end
    end

    // Debug state code; unknown encodings show as 4'hF.
    always_comb begin
        db_estado = 4'hF;
        case (estado)
            PARADO:   db_estado = 4'h0;
            CONTA:    db_estado = 4'h1;
            SORTEIA:  db_estado = 4'h2;
            SOLICITA: db_estado = 4'h3;
            AGUARDA:  db_estado = 4'h4;
            ATUALIZA: db_estado = 4'h5;
            default:  db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_agenda_asteroide.sv
// Directed testbench for agenda_asteroide (small periods so level-ups are quick).
module tb_agenda_asteroide;

  localparam int          P_INI  = 10;
  localparam int          P_MIN  = 2;
  localparam int          P_DEC  = 5;
  localparam int          P_SPN  = 8;
  localparam int          P_TMO  = 64;
  localparam int          P_LP   = 4;
  localparam logic [15:0] P_SEED = 16'hACE1;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            habilita = 1'b0;
  logic            pausa = 1'b0;
  logic            fim_gera_asteroide = 1'b0;
  logic            gera_asteroide;
  logic [P_LP-1:0] pos_x;
  logic [P_LP-1:0] pos_y;
  logic [2:0]      direcao;
  logic [3:0]      nivel;
  logic            timeout;
  logic [3:0]      db_estado;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [15:0]     m_lfsr;
  int              exp_per = P_INI;
  int              exp_niv = 0;
  int              exp_spawns = 0;
  logic            exp_to = 1'b0;
  logic [P_LP-1:0] exp_x = '0;
  logic [P_LP-1:0] exp_y = '0;
  logic [2:0]      exp_dir = '0;

  agenda_asteroide #(
    .PERIODO_INICIAL (P_INI),
    .PERIODO_MINIMO  (P_MIN),
    .DECREMENTO      (P_DEC),
    .SPAWNS_POR_NIVEL(P_SPN),
    .TIMEOUT         (P_TMO),
    .LARGURA_POS     (P_LP),
    .SEMENTE         (P_SEED)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .habilita          (habilita),
    .pausa             (pausa),
    .fim_gera_asteroide(fim_gera_asteroide),
    .gera_asteroide    (gera_asteroide),
    .pos_x             (pos_x),
    .pos_y             (pos_y),
    .direcao           (direcao),
    .nivel             (nivel),
    .timeout           (timeout),
    .db_estado         (db_estado)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // reference Galois LFSR, taps 16'hB400
  always @(posedge clock) begin
    if (!reset) m_lfsr <= P_SEED;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic step();
    @(negedge clock);
  endtask

  // Wait for the request pulse; exp_k = negedges from now until it is seen.
  task automatic wait_pulse(input string name, input int exp_k);
    int k;
    bit got;
    logic [15:0] prev;
    k = 0;
    got = 1'b0;
    prev = m_lfsr;
    while (!got && k < 400) begin
      prev = m_lfsr;
      step();
      k++;
      if (gera_asteroide === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got || k != exp_k) begin
      n_err++;
      $display("FAIL %s pulse_latency got=%0d (seen=%0d) exp=%0d", name, k, got, exp_k);
    end
    if (got) begin
      exp_x = prev[P_LP+1:2];
      exp_y = prev[2*P_LP+1:P_LP+2];
      exp_dir = prev[15:13];
      n_cmp++;
      if (pos_x !== exp_x || pos_y !== exp_y || direcao !== exp_dir) begin
        n_err++;
        $display("FAIL %s draw got x=%h y=%h d=%h exp x=%h y=%h d=%h",
                 name, pos_x, pos_y, direcao, exp_x, exp_y, exp_dir);
      end
      n_cmp++;
      if (nivel !== 4'(exp_niv)) begin
        n_err++;
        $display("FAIL %s nivel got=%0d exp=%0d", name, nivel, exp_niv);
      end
    end
  endtask

  // From the request cycle: fim raised after d cycles (d in 1..TIMEOUT).
  task automatic handshake(input string name, input int d);
    for (int i = 1; i <= d; i++) begin
      step();
      n_cmp++;
      if (gera_asteroide !== 1'b0 || db_estado !== 4'h4 ||
          pos_x !== exp_x || pos_y !== exp_y || direcao !== exp_dir) begin
        n_err++;
        $display("FAIL %s aguarda[%0d] got g=%b st=%h x=%h y=%h d=%h exp g=0 st=4 x=%h y=%h d=%h",
                 name, i, gera_asteroide, db_estado, pos_x, pos_y, direcao, exp_x, exp_y, exp_dir);
      end
    end
    fim_gera_asteroide = 1'b1;
    step();
    fim_gera_asteroide = 1'b0;
    n_cmp++;
    if (db_estado !== 4'h5 || timeout !== exp_to) begin
      n_err++;
      $display("FAIL %s atualiza got st=%h to=%b exp st=5 to=%b", name, db_estado, timeout, exp_to);
    end
    exp_spawns++;
    if (exp_spawns == P_SPN) begin
      exp_spawns = 0;
      if (exp_niv < 15) exp_niv++;
      if (exp_per - P_DEC < P_MIN) exp_per = P_MIN;
      else exp_per = exp_per - P_DEC;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    habilita = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (gera_asteroide !== 1'b0 || pos_x !== '0 || pos_y !== '0 || direcao !== '0 ||
        nivel !== 4'h0 || timeout !== 1'b0 || db_estado !== 4'h0) begin
      n_err++;
      $display("FAIL reset_values got g=%b x=%h y=%h d=%h n=%h to=%b st=%h exp all 0",
               gera_asteroide, pos_x, pos_y, direcao, nivel, timeout, db_estado);
    end
  endtask

  task automatic test_first_spawn();
    reset = 1'b1;
    wait_pulse("first_spawn", 12);
  endtask

  task automatic test_pausa();
    handshake("pausa_hs", 3);
    step();
    pausa = 1'b1;
    repeat (5) begin
      step();
      n_cmp++;
      if (db_estado !== 4'h1 || gera_asteroide !== 1'b0) begin
        n_err++;
        $display("FAIL pausa_hold got st=%h g=%b exp st=1 g=0", db_estado, gera_asteroide);
      end
    end
    pausa = 1'b0;
    wait_pulse("pausa_delay", exp_per + 1);
  endtask

  task automatic test_habilita();
    handshake("hab_hs", 3);
    repeat (4) step();
    habilita = 1'b0;
    step();
    n_cmp++;
    if (db_estado !== 4'h0) begin
      n_err++;
      $display("FAIL hab_parado got st=%h exp st=0", db_estado);
    end
    repeat (2) step();
    habilita = 1'b1;
    wait_pulse("hab_restart", exp_per + 2);
  endtask

  task automatic test_fim_ignored();
    handshake("ign_hs", 1);
    repeat (2) step();
    fim_gera_asteroide = 1'b1;
    step();
    fim_gera_asteroide = 1'b0;
    wait_pulse("fim_ignored", exp_per - 1);
  endtask

  task automatic test_level_up();
    int guard;
    guard = 0;
    while (exp_niv < 1 && guard < 20) begin
      handshake("lvl_hs", 3);
      wait_pulse("lvl_pulse", exp_per + 2);
      guard++;
    end
  endtask

  task automatic test_fim_on_last();
    handshake("fim_last_hs", P_TMO);
    wait_pulse("fim_last_pulse", exp_per + 2);
  endtask

  task automatic test_floor();
    int guard;
    guard = 0;
    while (exp_niv < 3 && guard < 40) begin
      handshake("floor_hs", 2);
      wait_pulse("floor_pulse", exp_per + 2);
      guard++;
    end
  endtask

  task automatic test_timeout();
    repeat (P_TMO) begin
      step();
      n_cmp++;
      if (db_estado !== 4'h4 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL tmo_wait got st=%h to=%b exp st=4 to=0", db_estado, timeout);
      end
    end
    step();
    exp_to = 1'b1;
    n_cmp++;
    if (db_estado !== 4'h1 || timeout !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_expire got st=%h to=%b exp st=1 to=1", db_estado, timeout);
    end
    wait_pulse("tmo_next", exp_per + 1);
  endtask

  task automatic test_saturation();
    int guard;
    int extra;
    guard = 0;
    extra = 0;
    while (extra < P_SPN + 1 && guard < 200) begin
      handshake("sat_hs", 2);
      wait_pulse("sat_pulse", exp_per + 2);
      if (exp_niv == 15) extra++;
      guard++;
    end
  endtask

  task automatic test_reset_mid();
    step();
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (gera_asteroide !== 1'b0 || pos_x !== '0 || pos_y !== '0 || direcao !== '0 ||
        nivel !== 4'h0 || timeout !== 1'b0 || db_estado !== 4'h0) begin
      n_err++;
      $display("FAIL reset_mid got g=%b x=%h y=%h d=%h n=%h to=%b st=%h exp all 0",
               gera_asteroide, pos_x, pos_y, direcao, nivel, timeout, db_estado);
    end
    exp_per = P_INI;
    exp_niv = 0;
    exp_spawns = 0;
    exp_to = 1'b0;
    step();
    reset = 1'b1;
    wait_pulse("after_reset", 12);
    handshake("after_reset_hs", 3);
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_pausa();
    test_habilita();
    test_fim_ignored();
    test_level_up();
    test_fim_on_last();
    test_floor();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
